// File: rtl/act_requant_pack.sv
// act_requant_pack: int32 lanes -> scale/round, ReLU, odd N-bit codes packed into BUS_W words; cfg_* latched on start, busy/done/sat_count status, act_in/out valid-ready streams with out_last
module act_requant_pack #(
  parameter int BUS_W = 128,
  parameter int ACC_W = 32,
  parameter int MULT_W = 16,
  parameter int SHIFT_W = 5
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [7:0]         cfg_out_bits,
  input  logic [7:0]         cfg_act_fn,
  input  logic               cfg_saturate_en,
  input  logic [MULT_W-1:0]  cfg_mult,
  input  logic [SHIFT_W-1:0] cfg_shift,
  input  logic [15:0]        cfg_h,
  input  logic [15:0]        cfg_w,
  input  logic [15:0]        cfg_c,
  input  logic               start,
  output logic               busy,
  output logic               done,
  output logic [31:0]        sat_count,
  input  logic [BUS_W-1:0]   act_in_data,
  input  logic               act_in_valid,
  output logic               act_in_ready,
  output logic [BUS_W-1:0]   out_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic               out_last
);
  localparam int L = BUS_W / ACC_W;
  localparam int PW = ACC_W + MULT_W;
  localparam int SW = PW + 2;
  localparam int PTR_W = $clog2(BUS_W) + 1;
  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
  state_t r_state;
  logic [4:0] r_n;
  logic r_relu, r_sat;
  logic signed [MULT_W-1:0] r_mult;
  logic [SHIFT_W-1:0] r_shift;
  logic [31:0] r_e, r_acc, r_sat_cnt;
  logic r_s1_v, r_s1_last, r_s2_v, r_s2_last;
  logic [L-1:0] r_s1_m, r_s2_m;
  logic signed [PW-1:0] r_s1_p [L];
  logic [15:0] r_s2_code [L];
  logic [BUS_W-1:0] r_pack, r_out_data;
  logic [PTR_W-1:0] r_ptr;
  logic r_out_valid, r_out_last;
  logic w_stall, w_fire, w_in_last, w_emit;
  logic [31:0] w_rem, w_e;
  logic [L-1:0] w_in_m, w_sat;
  logic [15:0] w_code [L];
  logic [BUS_W-1:0] w_beat, w_pack_nx;
  logic [PTR_W-1:0] w_ptr_nx;
  assign w_stall = r_out_valid && !out_ready;
  assign act_in_ready = r_state == RUN && !w_stall;
  assign w_fire = act_in_valid && act_in_ready;
  assign w_rem = r_e - r_acc;
  assign w_in_last = w_rem <= 32'(L);
  assign w_e = 32'(cfg_h) * 32'(cfg_w) * 32'(cfg_c);
  assign busy = r_state != IDLE;
  assign done = r_state == DONE;
  assign sat_count = r_sat_cnt;
  assign out_data = r_out_data;
  assign out_valid = r_out_valid;
  assign out_last = r_out_last;
  for (genvar g = 0; g < L; g++) begin : g_lane
    logic signed [SW-1:0] w_p, w_a, w_h, w_r, w_s, w_c, w_o, w_v, w_mx, w_k;
    logic w_c1, w_c2;
    assign w_p = SW'(r_s1_p[g]);
    assign w_mx = (SW'(1) <<< r_n) - SW'(1);
    assign w_a = w_p < 0 ? -w_p : w_p;
    assign w_h = (w_a + (SW'(1) <<< (r_shift - SHIFT_W'(1)))) >>> r_shift;
    assign w_r = r_shift == '0 ? w_p : (w_p < 0 ? -w_h : w_h);
    assign w_s = r_relu && w_r < 0 ? '0 : w_r;
    assign w_c1 = r_sat && (w_s > w_mx || w_s < -w_mx);
    assign w_c = w_c1 ? (w_s < 0 ? -w_mx : w_mx) : w_s;
    assign w_o = w_c[0] ? w_c : (w_c < 0 ? w_c - SW'(1) : w_c + SW'(1));
    assign w_c2 = r_sat && (w_o > w_mx || w_o < -w_mx);
    assign w_v = w_c2 ? (w_o < 0 ? -w_mx : w_mx) : w_o;
    assign w_k = (w_v + w_mx) >>> 1;
    assign w_code[g] = 16'(w_k & w_mx);
    assign w_sat[g] = r_s1_m[g] && (w_c1 || w_c2);
  end
  always_comb begin
    w_in_m = '0;
    w_beat = '0;
    for (int i = 0; i < L; i++) begin
      w_in_m[i] = 32'(i) < w_rem;
      w_beat = w_beat | (r_s2_m[i] ? BUS_W'(r_s2_code[i]) << (i * r_n) : '0);
    end
  end
  // Every non-final beat is full and L*N divides BUS_W, so a beat never straddles two words.
  assign w_ptr_nx = r_s2_v ? r_ptr + PTR_W'($countones(r_s2_m) * r_n) : r_ptr;
  assign w_pack_nx = r_s2_v ? r_pack | (w_beat << r_ptr) : r_pack;
  assign w_emit = r_s2_v && (w_ptr_nx == PTR_W'(BUS_W) || r_s2_last);
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_sat_cnt <= '0;
      r_acc <= '0;
      r_e <= '0;
      r_s1_v <= 1'b0;
      r_s2_v <= 1'b0;
      r_pack <= '0;
      r_ptr <= '0;
      r_out_valid <= 1'b0;
      r_out_last <= 1'b0;
      r_out_data <= '0;
    end else begin
      if (r_state == IDLE && start) begin
        r_n <= cfg_out_bits == 8'd4 ? 5'd4 : cfg_out_bits == 8'd8 ? 5'd8 : cfg_out_bits == 8'd16 ? 5'd16 : 5'd2;
        r_relu <= cfg_act_fn == 8'd1;
        r_sat <= cfg_saturate_en;
        r_mult <= cfg_mult;
        r_shift <= cfg_shift;
        r_e <= w_e;
        r_acc <= '0;
        r_sat_cnt <= '0;
        r_state <= w_e == '0 ? DONE : RUN;
      end
      if (w_fire) begin
        r_acc <= r_acc + 32'(L);
        if (w_in_last) r_state <= DRAIN;
      end
      if (r_state == DRAIN && r_out_valid && out_ready && r_out_last) r_state <= DONE;
      if (r_state == DONE) r_state <= IDLE;
      if (!w_stall) begin
        r_s1_v <= w_fire;
        r_s1_last <= w_in_last;
        r_s1_m <= w_in_m;
        for (int i = 0; i < L; i++) r_s1_p[i] <= PW'(signed'(act_in_data[i*ACC_W +: ACC_W])) * PW'(r_mult);
        r_s2_v <= r_s1_v;
        r_s2_last <= r_s1_last;
        r_s2_m <= r_s1_m;
        r_s2_code <= w_code;
        if (r_s1_v) r_sat_cnt <= r_sat_cnt + 32'($countones(w_sat));
        r_out_valid <= w_emit;
        r_out_last <= w_emit && r_s2_last;
        r_out_data <= w_pack_nx;
        r_pack <= w_emit ? '0 : w_pack_nx;
        r_ptr <= w_emit ? '0 : w_ptr_nx;
      end
    end
  end
endmodule
